qracc_sram_bridge: RTL and testbench

// Bridges the 32-bit generic data bus (qracc_data_interface slave) to the row-wide

---
 rtl/qracc_sram_bridge.sv | 124 ++++++++++++
 tb/tb_qracc_sram_bridge.sv | 347 ++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/qracc_sram_bridge.sv
// Bridges the 32-bit word bus to the row-wide QRAcc SRAM port: packs words into a row
// buffer, commits on the last word of a row, and serves reads by fetching a whole row.
module qracc_sram_bridge #(
    parameter int numRows   = 128,
    parameter int numCols   = 32,
    parameter int dataWidth = 32
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic [dataWidth-1:0]       bus_data_in_i,
    input  logic [31:0]                bus_addr_i,
    input  logic                       bus_wen_i,
    input  logic                       bus_valid_i,
    output logic                       bus_ready_o,
    output logic [dataWidth-1:0]       bus_data_out_o,
    output logic                       bus_rd_data_valid_o,
    output logic                       addr_err_o,
    output logic                       sram_rq_wr_o,
    output logic                       sram_rq_valid_o,
    input  logic                       sram_rq_ready_i,
    input  logic                       sram_rd_valid_i,
    input  logic [numCols-1:0]         sram_rd_data_i,
    output logic [numCols-1:0]         sram_wr_data_o,
    output logic [$clog2(numRows)-1:0] sram_addr_o
);

    localparam int          WPR        = numCols / dataWidth;
    localparam int          AW         = $clog2(numRows);
    localparam int          WW         = (WPR > 1) ? $clog2(WPR) : 1;
    localparam logic [31:0] WPR_L      = 32'(WPR);
    localparam logic [31:0] ADDR_LIMIT = 32'(numRows * WPR);

    typedef enum logic [1:0] {
        IDLE,
        SRAM_REQ,
        SRAM_WAIT_RD,
        RESP
    } state_t;

    state_t               state;
    logic [numCols-1:0]   row_buf;
    logic [WW-1:0]        rd_word;

    logic [AW-1:0]        row_idx;
    logic [WW-1:0]        word_idx;
    logic                 in_range;
    logic                 last_word;
    logic                 accept;

    assign row_idx   = AW'(bus_addr_i / WPR_L);
    assign word_idx  = WW'(bus_addr_i % WPR_L);
    assign last_word = ((bus_addr_i % WPR_L) == (WPR_L - 32'd1));
    assign in_range  = (bus_addr_i < ADDR_LIMIT);

    assign bus_ready_o    = (state == IDLE) && !rst;
    assign accept         = bus_valid_i && bus_ready_o;
    assign sram_wr_data_o = row_buf;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state               <= IDLE;
            row_buf             <= '0;
            rd_word             <= '0;
            sram_rq_valid_o     <= 1'b0;
            sram_rq_wr_o        <= 1'b0;
            sram_addr_o         <= '0;
            bus_data_out_o      <= '0;
            bus_rd_data_valid_o <= 1'b0;
            addr_err_o          <= 1'b0;
        end else begin
            addr_err_o          <= 1'b0;
            bus_rd_data_valid_o <= 1'b0;
            case (state)
                IDLE: begin
                    if (accept) begin
                        if (!in_range) begin
                            // Out-of-range writes vanish; reads answer zero without touching SRAM.
                            addr_err_o <= 1'b1;
                            if (!bus_wen_i) begin
                                bus_data_out_o      <= '0;
                                bus_rd_data_valid_o <= 1'b1;
                                state               <= RESP;
                            end
                        end else if (bus_wen_i) begin
                            row_buf[int'(word_idx) * dataWidth +: dataWidth] <= bus_data_in_i;
                            if (last_word) begin
                                sram_addr_o     <= row_idx;
                                sram_rq_wr_o    <= 1'b1;
                                sram_rq_valid_o <= 1'b1;
                                state           <= SRAM_REQ;
                            end
                        end else begin
                            sram_addr_o     <= row_idx;
                            rd_word         <= word_idx;
                            sram_rq_wr_o    <= 1'b0;
                            sram_rq_valid_o <= 1'b1;
                            state           <= SRAM_REQ;
                        end
                    end
                end
                SRAM_REQ: begin
                    if (sram_rq_ready_i) begin
                        sram_rq_valid_o <= 1'b0;
                        state           <= sram_rq_wr_o ? IDLE : SRAM_WAIT_RD;
                    end
                end
                SRAM_WAIT_RD: begin
                    if (sram_rd_valid_i) begin
                        bus_data_out_o      <= sram_rd_data_i[int'(rd_word) * dataWidth +: dataWidth];
                        bus_rd_data_valid_o <= 1'b1;
                        state               <= RESP;
                    end
                end
                RESP: begin
                    state <= IDLE;
                end
                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_qracc_sram_bridge.sv
// Bench for qracc_sram_bridge: one instance with one word per row, one with two words per row.
module tb_qracc_sram_bridge;

    logic        clk;
    logic        rst;
    int          cyc = 0;
    int          tests = 0;
    int          fails = 0;

    logic        bus_valid [2];
    logic        bus_wen   [2];
    logic [31:0] bus_addr  [2];
    logic [31:0] bus_din   [2];
    logic        bus_ready [2];
    logic [31:0] dout      [2];
    logic        rd_strobe [2];
    logic        addr_err  [2];
    logic        rq_wr     [2];
    logic        rq_valid  [2];
    logic        rq_ready  [2];
    logic        rd_valid  [2];
    logic [63:0] rd_data   [2];
    logic [63:0] wr_data   [2];
    logic [6:0]  sram_addr [2];
    logic [31:0] wr_data0;
    logic [63:0] wr_data1;

    assign wr_data[0] = {32'h0, wr_data0};
    assign wr_data[1] = wr_data1;

    qracc_sram_bridge #(.numRows(128), .numCols(32), .dataWidth(32)) u_dut0 (
        .clk(clk), .rst(rst),
        .bus_data_in_i(bus_din[0]), .bus_addr_i(bus_addr[0]), .bus_wen_i(bus_wen[0]),
        .bus_valid_i(bus_valid[0]), .bus_ready_o(bus_ready[0]), .bus_data_out_o(dout[0]),
        .bus_rd_data_valid_o(rd_strobe[0]), .addr_err_o(addr_err[0]),
        .sram_rq_wr_o(rq_wr[0]), .sram_rq_valid_o(rq_valid[0]), .sram_rq_ready_i(rq_ready[0]),
        .sram_rd_valid_i(rd_valid[0]), .sram_rd_data_i(rd_data[0][31:0]),
        .sram_wr_data_o(wr_data0), .sram_addr_o(sram_addr[0])
    );

    qracc_sram_bridge #(.numRows(128), .numCols(64), .dataWidth(32)) u_dut1 (
        .clk(clk), .rst(rst),
        .bus_data_in_i(bus_din[1]), .bus_addr_i(bus_addr[1]), .bus_wen_i(bus_wen[1]),
        .bus_valid_i(bus_valid[1]), .bus_ready_o(bus_ready[1]), .bus_data_out_o(dout[1]),
        .bus_rd_data_valid_o(rd_strobe[1]), .addr_err_o(addr_err[1]),
        .sram_rq_wr_o(rq_wr[1]), .sram_rq_valid_o(rq_valid[1]), .sram_rq_ready_i(rq_ready[1]),
        .sram_rd_valid_i(rd_valid[1]), .sram_rd_data_i(rd_data[1]),
        .sram_wr_data_o(wr_data1), .sram_addr_o(sram_addr[1])
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    initial forever begin
        @(posedge clk);
        cyc++;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not reach its end");
        $fatal(1, "watchdog expired");
    end

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %0h, want %0h", name, act, exp);
        end
    endtask

    // Transaction-level model: expected SRAM requests, row buffer contents, backing memory.
    typedef struct packed {
        logic       wr;
        logic [6:0] addr;
    } req_t;

    req_t        exp_q [2][$];
    logic [63:0] buf_m [2];
    logic [63:0] mem   [2][128];
    logic [31:0] last_rd [2];
    logic        err_due [2];
    logic        strobe_due [2];
    logic        rd_wait [2];
    logic        in_req [2];
    logic        spur [2];
    int          rd_cnt [2];
    int          rd_row [2];
    int          rd_word_m [2];
    int          stall_left [2];
    int          stall_cfg [2];
    int          rd_lat_cfg [2];
    int          wr_cnt [2];
    int          err_cnt [2];
    int          acc_cyc [2];
    int          strobe_cyc [2];
    logic [31:0] rd_last [2];
    int          m_wpr, m_row, m_word;
    logic        m_busy;
    req_t        m_h;

    initial begin
        for (int d = 0; d < 2; d++) begin
            for (int r = 0; r < 128; r++)
                mem[d][r] = {32'(r) ^ 32'h5A5A0000, 32'(r) | 32'hC0DE0000};
            wr_cnt[d] = 0; err_cnt[d] = 0; acc_cyc[d] = 0; strobe_cyc[d] = 0; rd_last[d] = 32'h0;
            rq_ready[d] = 1'b0; rd_valid[d] = 1'b0; rd_data[d] = 64'h0;
        end
        mem[1][2] = 64'hCAFEF00D_0BADC0DE;
        mem[1][4] = 64'hAAAA5555_12345678;
        forever begin
            @(negedge clk);
            for (int d = 0; d < 2; d++) begin
                if (rst) begin
                    exp_q[d].delete();
                    buf_m[d] = 64'h0; last_rd[d] = 32'h0;
                    err_due[d] = 0; strobe_due[d] = 0; rd_wait[d] = 0; in_req[d] = 0;
                    rq_ready[d] = 1'b0; rd_valid[d] = 1'b0;
                    chk($sformatf("rst_ready%0d", d), 64'(bus_ready[d]), 64'h0);
                    chk($sformatf("rst_rqvalid%0d", d), 64'(rq_valid[d]), 64'h0);
                    chk($sformatf("rst_buf%0d", d), wr_data[d], 64'h0);
                    chk($sformatf("rst_dout%0d", d), 64'(dout[d]), 64'h0);
                    continue;
                end
                m_busy = (exp_q[d].size() != 0) || rd_wait[d] || strobe_due[d];
                chk($sformatf("ready%0d", d), 64'(bus_ready[d]), 64'(!m_busy));
                chk($sformatf("addr_err%0d", d), 64'(addr_err[d]), 64'(err_due[d]));
                chk($sformatf("strobe%0d", d), 64'(rd_strobe[d]), 64'(strobe_due[d]));
                chk($sformatf("dout%0d", d), 64'(dout[d]), 64'(last_rd[d]));
                chk($sformatf("rowbuf%0d", d), wr_data[d], buf_m[d]);
                if (exp_q[d].size() != 0) begin
                    m_h = exp_q[d][0];
                    chk($sformatf("rq_valid%0d", d), 64'(rq_valid[d]), 64'h1);
                    chk($sformatf("rq_wr%0d", d), 64'(rq_wr[d]), 64'(m_h.wr));
                    chk($sformatf("rq_addr%0d", d), 64'(sram_addr[d]), 64'(m_h.addr));
                end else begin
                    chk($sformatf("rq_idle%0d", d), 64'(rq_valid[d]), 64'h0);
                end
                if (rd_strobe[d]) begin
                    rd_last[d] = dout[d];
                    strobe_cyc[d] = cyc;
                end
                if (addr_err[d]) err_cnt[d]++;
                err_due[d] = 0;
                strobe_due[d] = 0;
                // SRAM read return, k cycles after the handshake
                rd_valid[d] = spur[d];
                rd_data[d] = 64'hBAD0BAD0_BAD0BAD0;
                if (rd_wait[d]) begin
                    rd_cnt[d]--;
                    if (rd_cnt[d] <= 0) begin
                        rd_valid[d] = 1'b1;
                        rd_data[d] = mem[d][rd_row[d]];
                        last_rd[d] = mem[d][rd_row[d]][rd_word_m[d] * 32 +: 32];
                        strobe_due[d] = 1;
                        rd_wait[d] = 0;
                    end
                end
                // SRAM request acceptance with programmable stall
                if (rq_valid[d]) begin
                    if (!in_req[d]) begin
                        in_req[d] = 1;
                        stall_left[d] = stall_cfg[d];
                    end
                    if (stall_left[d] > 0) begin
                        rq_ready[d] = 1'b0;
                        stall_left[d]--;
                    end else begin
                        rq_ready[d] = 1'b1;
                    end
                end else begin
                    rq_ready[d] = 1'b0;
                end
                if (rq_valid[d] && rq_ready[d] && exp_q[d].size() != 0) begin
                    m_h = exp_q[d].pop_front();
                    in_req[d] = 0;
                    if (m_h.wr) begin
                        mem[d][m_h.addr] = buf_m[d];
                        wr_cnt[d]++;
                    end else begin
                        rd_wait[d] = 1;
                        rd_cnt[d] = rd_lat_cfg[d];
                        rd_row[d] = int'(m_h.addr);
                    end
                end
                // Bus request accepted at the coming edge
                if (bus_valid[d] && bus_ready[d]) begin
                    acc_cyc[d] = cyc;
                    m_wpr = (d == 0) ? 1 : 2;
                    m_row = int'(bus_addr[d]) / m_wpr;
                    m_word = int'(bus_addr[d]) % m_wpr;
                    if (bus_addr[d] >= 32'(128 * m_wpr)) begin
                        err_due[d] = 1;
                        if (!bus_wen[d]) begin
                            strobe_due[d] = 1;
                            last_rd[d] = 32'h0;
                        end
                    end else if (bus_wen[d]) begin
                        buf_m[d][m_word * 32 +: 32] = bus_din[d];
                        if (m_word == m_wpr - 1) begin
                            m_h.wr = 1'b1; m_h.addr = 7'(m_row);
                            exp_q[d].push_back(m_h);
                        end
                    end else begin
                        m_h.wr = 1'b0; m_h.addr = 7'(m_row);
                        exp_q[d].push_back(m_h);
                        rd_word_m[d] = m_word;
                    end
                end
            end
        end
    end

    task automatic idle(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic wait_idle(input int d);
        for (int i = 0; i < 100; i++) begin
            if (bus_ready[d]) return;
            @(posedge clk);
            #1;
        end
        tests++;
        fails++;
        $display("FAIL idle_timeout%0d: bus_ready still 0, want 1 within 100 cycles", d);
    endtask

    task automatic bus_op(input int d, input logic wen, input logic [31:0] addr, input logic [31:0] data);
        wait_idle(d);
        bus_valid[d] = 1'b1;
        bus_wen[d] = wen;
        bus_addr[d] = addr;
        bus_din[d] = data;
        @(posedge clk);
        #1;
        bus_valid[d] = 1'b0;
    endtask

    int e0, w0;

    initial begin
        rst = 1'b1;
        for (int d = 0; d < 2; d++) begin
            bus_valid[d] = 0; bus_wen[d] = 0; bus_addr[d] = 0; bus_din[d] = 0;
            spur[d] = 0; stall_cfg[d] = 0; rd_lat_cfg[d] = 1;
        end
        idle(2);
        for (int d = 0; d < 2; d++) begin
            chk($sformatf("reset_ready%0d", d), 64'(bus_ready[d]), 64'h0);
            chk($sformatf("reset_rqwr%0d", d), 64'(rq_wr[d]), 64'h0);
            chk($sformatf("reset_addr%0d", d), 64'(sram_addr[d]), 64'h0);
            chk($sformatf("reset_strobe%0d", d), 64'(rd_strobe[d]), 64'h0);
        end
        idle(1);
        rst = 1'b0;

        // One word per row: direct commit, then read back
        bus_op(0, 1'b1, 32'd5, 32'hDEADBEEF);
        wait_idle(0);
        chk("wpr1_mem5", mem[0][5], 64'h00000000_DEADBEEF);
        chk("wpr1_wrcnt", 64'(wr_cnt[0]), 64'd1);
        bus_op(0, 1'b0, 32'd5, 32'h0);
        wait_idle(0);
        chk("wpr1_rd", 64'(rd_last[0]), 64'hDEADBEEF);
        chk("wpr1_rd_lat", 64'(strobe_cyc[0] - acc_cyc[0]), 64'd3);

        // Two words per row: a single commit of row 3
        bus_op(1, 1'b1, 32'd6, 32'h11111111);
        bus_op(1, 1'b1, 32'd7, 32'h22222222);
        wait_idle(1);
        chk("pack_wrcnt", 64'(wr_cnt[1]), 64'd1);
        chk("pack_row3", mem[1][3], 64'h22222222_11111111);

        // Read of row 2 with three stalled request cycles
        stall_cfg[1] = 3;
        bus_op(1, 1'b0, 32'd4, 32'h0);
        wait_idle(1);
        chk("stall_rd", 64'(rd_last[1]), 64'h0BADC0DE);
        chk("stall_lat", 64'(strobe_cyc[1] - acc_cyc[1]), 64'd6);
        stall_cfg[1] = 0;

        // Upper word of row 4, data two cycles after handshake
        rd_lat_cfg[1] = 2;
        bus_op(1, 1'b0, 32'd9, 32'h0);
        wait_idle(1);
        chk("rd_hi", 64'(rd_last[1]), 64'hAAAA5555);
        chk("rd_hi_lat", 64'(strobe_cyc[1] - acc_cyc[1]), 64'd4);
        rd_lat_cfg[1] = 1;

        // Out of range write and read
        e0 = err_cnt[1];
        w0 = wr_cnt[1];
        bus_op(1, 1'b1, 32'd256, 32'hFFFFFFFF);
        idle(2);
        bus_op(1, 1'b0, 32'd256, 32'h0);
        wait_idle(1);
        idle(1);
        chk("oor_errs", 64'(err_cnt[1] - e0), 64'd2);
        chk("oor_nowrite", 64'(wr_cnt[1] - w0), 64'd0);
        chk("oor_rd", 64'(rd_last[1]), 64'h0);
        bus_op(0, 1'b1, 32'd128, 32'h12345678);
        idle(2);
        chk("oor_err0", 64'(err_cnt[0]), 64'd1);

        // Out-of-order and repeated words before the committing word
        bus_op(1, 1'b1, 32'd11, 32'hA1A1A1A1);
        bus_op(1, 1'b1, 32'd10, 32'hB2B2B2B2);
        bus_op(1, 1'b1, 32'd10, 32'hC3C3C3C3);
        bus_op(1, 1'b1, 32'd11, 32'hD4D4D4D4);
        wait_idle(1);
        chk("ooo_row5", mem[1][5], 64'hD4D4D4D4_C3C3C3C3);

        // Stray read-data strobe while idle must not disturb the response register
        spur[1] = 1'b1;
        idle(1);
        spur[1] = 1'b0;
        idle(3);

        // Reset while a write request is stalled
        stall_cfg[1] = 50;
        bus_op(1, 1'b1, 32'd0, 32'h55555555);
        bus_op(1, 1'b1, 32'd1, 32'h66666666);
        idle(2);
        chk("pre_rst_valid", 64'(rq_valid[1]), 64'h1);
        rst = 1'b1;
        #1;
        chk("rst_drops_valid", 64'(rq_valid[1]), 64'h0);
        idle(2);
        rst = 1'b0;
        stall_cfg[1] = 0;
        bus_op(1, 1'b1, 32'd1, 32'h33333333);
        wait_idle(1);
        chk("post_rst_row0", mem[1][0], 64'h33333333_00000000);

        idle(3);
        for (int d = 0; d < 2; d++)
            chk($sformatf("drained%0d", d), 64'(exp_q[d].size()), 64'h0);
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
